// File: rtl/uart_msg_serialiser.sv
// rtl/uart_msg_serialiser.sv - serialises one controller message into a header-first UART byte stream
// Optional trailing two's-complement checksum byte: define UART_MSG_CHECKSUM_EN.
module uart_msg_serialiser #(
  parameter int MSG_BYTES = 8
) (
  input  logic                   clk,
  input  logic                   n_reset,
  output logic                   uart_out_ready,
  input  logic [MSG_BYTES*8-1:0] uart_out_msg,
  input  logic                   uart_out_req,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   msg_done,
  output logic                   req_err
);

  localparam int CNT_W = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MSG_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND
`ifdef UART_MSG_CHECKSUM_EN
    , CSUM
`endif
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [MSG_BYTES*8-1:0] shift;
  logic [CNT_W-1:0]       cnt;
  logic                   done_nxt;
`ifdef UART_MSG_CHECKSUM_EN
  logic [7:0]             acc;
`endif

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // uart_out_ready is a pure decode of the state register, so it never
  // depends combinationally on uart_out_req or tx_ready.
  always_comb begin
    state_nxt      = state;
    uart_out_ready = 1'b0;
    tx_valid       = 1'b0;
    tx_data        = 8'h00;
    done_nxt       = 1'b0;
    case (state)
      IDLE: begin
        uart_out_ready = 1'b1;
        if (uart_out_req) begin
          state_nxt = SEND;
        end
      end
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = shift[7:0];
        if (tx_ready && (cnt == LAST_IDX)) begin
`ifdef UART_MSG_CHECKSUM_EN
          state_nxt = CSUM;
`else
          state_nxt = IDLE;
          done_nxt  = 1'b1;
`endif
        end
      end
`ifdef UART_MSG_CHECKSUM_EN
      CSUM: begin
        tx_valid = 1'b1;
        tx_data  = ~acc + 8'd1;
        if (tx_ready) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      shift    <= '0;
      cnt      <= '0;
      msg_done <= 1'b0;
      req_err  <= 1'b0;
`ifdef UART_MSG_CHECKSUM_EN
      acc      <= 8'h00;
`endif
    end else begin
      msg_done <= done_nxt;
      if (uart_out_req && !uart_out_ready) begin
        req_err <= 1'b1;
      end
      if ((state == IDLE) && uart_out_req) begin
        shift <= uart_out_msg;
        cnt   <= '0;
`ifdef UART_MSG_CHECKSUM_EN
        acc   <= 8'h00;
`endif
      end else if ((state == SEND) && tx_ready) begin
        shift <= shift >> 8;
        cnt   <= cnt + CNT_W'(1);
`ifdef UART_MSG_CHECKSUM_EN
        acc   <= acc + shift[7:0];
`endif
      end
    end
  end

endmodule

// File: tb/tb_uart_msg_serialiser.sv
// tb/tb_uart_msg_serialiser.sv - scoreboard bench for uart_msg_serialiser
// Honours UART_MSG_CHECKSUM_EN the same way as the design.
module tb_uart_msg_serialiser;

  localparam int MSG_BYTES = 8;
`ifdef UART_MSG_CHECKSUM_EN
  localparam int NB = MSG_BYTES + 1;
`else
  localparam int NB = MSG_BYTES;
`endif

  logic                   clk = 1'b0;
  logic                   n_reset = 1'b0;
  logic                   uart_out_req = 1'b0;
  logic                   tx_ready = 1'b1;
  logic [MSG_BYTES*8-1:0] uart_out_msg = '0;
  logic                   uart_out_ready;
  logic                   tx_valid;
  logic                   msg_done;
  logic                   req_err;
  logic [7:0]             tx_data;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_msg_serialiser #(.MSG_BYTES(MSG_BYTES)) dut (
    .clk            (clk),
    .n_reset        (n_reset),
    .uart_out_ready (uart_out_ready),
    .uart_out_msg   (uart_out_msg),
    .uart_out_req   (uart_out_req),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .msg_done       (msg_done),
    .req_err        (req_err)
  );

  // Expected wire order: header (low byte) first, then checksum making the byte sum zero.
  function automatic void push_msg(input logic [MSG_BYTES*8-1:0] m);
    for (int i = 0; i < MSG_BYTES; i++) exp_q.push_back(m[8*i +: 8]);
`ifdef UART_MSG_CHECKSUM_EN
    begin
      logic [7:0] sum;
      sum = 8'h00;
      for (int i = 0; i < MSG_BYTES; i++) sum = sum + m[8*i +: 8];
      exp_q.push_back(8'h00 - sum);
    end
`endif
  endfunction

  task automatic test_reset();
    n_reset = 1'b0; uart_out_req = 1'b0; tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++;
      if ({uart_out_ready, tx_valid, msg_done, req_err} !== 4'b1000) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: ready/valid/done/err=%b expected 1000", c,
                 {uart_out_ready, tx_valid, msg_done, req_err});
      end
    end
    n_checks++;
    if (tx_data !== 8'h00) begin
      n_fail++; $display("FAIL reset_tx_data: got %h expected 00", tx_data);
    end
  endtask

  task automatic test_basic();
    logic [63:0] m;
    logic [7:0]  e;
    m = 64'h0807060504030201;
    exp_q.delete(); push_msg(m);
    uart_out_msg = m; uart_out_req = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    uart_out_req = 1'b0; uart_out_msg = '1;
    for (int k = 0; k < NB; k++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== e) begin
        n_fail++; $display("FAIL basic_byte %0d: valid=%b data=%h expected valid=1 data=%h", k, tx_valid, tx_data, e);
      end
      n_checks++;
      if (msg_done !== 1'b0 || uart_out_ready !== 1'b0) begin
        n_fail++; $display("FAIL basic_busy %0d: done=%b ready=%b expected 0 0", k, msg_done, uart_out_ready);
      end
      @(negedge clk);
    end
    n_checks++;
    if (msg_done !== 1'b1 || uart_out_ready !== 1'b1 || tx_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_done: done=%b ready=%b valid=%b expected 1 1 0", msg_done, uart_out_ready, tx_valid);
    end
    @(negedge clk);
    n_checks++;
    if (msg_done !== 1'b0) begin
      n_fail++; $display("FAIL basic_done_pulse: done=%b expected 0", msg_done);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] m;
    logic [7:0]  e;
    int got, stall, cyc;
    m = 64'h0807060504030201;
    got = 0; stall = 0; cyc = 0;
    exp_q.delete(); push_msg(m);
    uart_out_msg = m; uart_out_req = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    uart_out_req = 1'b0;
    while (got < NB && cyc < 100) begin
      tx_ready = (got == 3 && stall < 5) ? 1'b0 : 1'b1;
      n_checks++;
      if (tx_valid !== 1'b1) begin
        n_fail++; $display("FAIL bp_valid byte %0d: valid=%b expected 1", got, tx_valid);
      end
      if (tx_ready) begin
        e = exp_q.pop_front();
        n_checks++;
        if (tx_data !== e) begin
          n_fail++; $display("FAIL bp_byte %0d: got %h expected %h", got, tx_data, e);
        end
        got++;
      end else begin
        n_checks++;
        if (tx_data !== 8'h04) begin
          n_fail++; $display("FAIL bp_hold stall %0d: got %h expected 04", stall, tx_data);
        end
        stall++;
      end
      @(negedge clk);
      cyc++;
    end
    tx_ready = 1'b1;
    n_checks++;
    if (got != NB || stall != 5) begin
      n_fail++; $display("FAIL bp_count: bytes %0d stalls %0d expected %0d and 5", got, stall, NB);
    end
    n_checks++;
    if (msg_done !== 1'b1 || tx_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_done: done=%b valid=%b expected 1 0", msg_done, tx_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [63:0] m1, m2;
    logic [7:0]  e;
    m1 = 64'h0807060504030201;
    m2 = 64'h1111111111111111;
    exp_q.delete(); push_msg(m1); push_msg(m2);
    uart_out_msg = m1; uart_out_req = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    uart_out_req = 1'b0;
    for (int k = 0; k < 2 * NB; k++) begin
      if (k == NB) begin
        n_checks++;
        if (msg_done !== 1'b1 || uart_out_ready !== 1'b1) begin
          n_fail++; $display("FAIL b2b_first_done: done=%b ready=%b expected 1 1", msg_done, uart_out_ready);
        end
        uart_out_msg = m2; uart_out_req = 1'b1;
        @(negedge clk);
        uart_out_req = 1'b0;
      end
      e = exp_q.pop_front();
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== e) begin
        n_fail++; $display("FAIL b2b_byte %0d: valid=%b data=%h expected valid=1 data=%h", k, tx_valid, tx_data, e);
      end
      @(negedge clk);
    end
    n_checks++;
    if (msg_done !== 1'b1 || req_err !== 1'b0) begin
      n_fail++; $display("FAIL b2b_second_done: done=%b err=%b expected 1 0", msg_done, req_err);
    end
    @(negedge clk);
  endtask

  task automatic test_illegal_req();
    logic [63:0] m1, m2;
    logic [7:0]  e;
    m1 = 64'h0807060504030201;
    m2 = 64'hA5A5A5A5A5A5A5A5;
    exp_q.delete(); push_msg(m1);
    uart_out_msg = m1; uart_out_req = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    uart_out_req = 1'b0;
    for (int k = 0; k < NB; k++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== e) begin
        n_fail++; $display("FAIL illegal_byte %0d: valid=%b data=%h expected valid=1 data=%h", k, tx_valid, tx_data, e);
      end
      if (k == 3) begin
        n_checks++;
        if (req_err !== 1'b1) begin
          n_fail++; $display("FAIL illegal_err_set: err=%b expected 1", req_err);
        end
      end
      uart_out_req = (k == 2);
      if (k == 2) uart_out_msg = m2;
      @(negedge clk);
    end
    uart_out_req = 1'b0;
    n_checks++;
    if (msg_done !== 1'b1) begin
      n_fail++; $display("FAIL illegal_done: done=%b expected 1", msg_done);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (tx_valid !== 1'b0 || req_err !== 1'b1) begin
        n_fail++; $display("FAIL illegal_after %0d: valid=%b err=%b expected 0 1", c, tx_valid, req_err);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] m, m3;
    logic [7:0]  e;
    m  = 64'h0807060504030201;
    m3 = 64'h0123456789ABCDEF;
    exp_q.delete(); push_msg(m);
    uart_out_msg = m; uart_out_req = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    uart_out_req = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h04) begin
      n_fail++; $display("FAIL rstmid_pre: valid=%b data=%h expected 1 04", tx_valid, tx_data);
    end
    n_reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (tx_valid !== 1'b0 || msg_done !== 1'b0 || uart_out_ready !== 1'b1 || req_err !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_reset: valid=%b done=%b ready=%b err=%b expected 0 0 1 0",
                         tx_valid, msg_done, uart_out_ready, req_err);
    end
    n_reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (tx_valid !== 1'b0 || msg_done !== 1'b0 || uart_out_ready !== 1'b1) begin
        n_fail++; $display("FAIL rstmid_idle %0d: valid=%b done=%b ready=%b expected 0 0 1", c, tx_valid, msg_done, uart_out_ready);
      end
    end
    exp_q.delete(); push_msg(m3);
    uart_out_msg = m3; uart_out_req = 1'b1;
    @(negedge clk);
    uart_out_req = 1'b0;
    for (int k = 0; k < NB; k++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== e) begin
        n_fail++; $display("FAIL rstmid_byte %0d: valid=%b data=%h expected valid=1 data=%h", k, tx_valid, tx_data, e);
      end
      @(negedge clk);
    end
    n_checks++;
    if (msg_done !== 1'b1 || uart_out_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_done: done=%b ready=%b expected 1 1", msg_done, uart_out_ready);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_illegal_req();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_msg_serialiser.md
# uart_msg_serialiser

Converts one fixed-width message from the controller's UART output interface into a byte stream for the UART transmitter. It sits between the controller (uart_out_ready / uart_out_msg / uart_out_req) and the UART TX byte sink, and is the responder on that handshake. It emits the header byte first, then the payload bytes in ascending order. A compile-time option appends a checksum byte.

## Interface
- MSG_BYTES, 8, message width in bytes (≥2); uart_out_msg is MSG_BYTES*8 bits, header in bits [7:0]
- clk  input  1  clock
- n_reset  input  1  reset, synchronous, active-low
- uart_out_ready  output  1  high when a new message can be accepted
- uart_out_msg  input  MSG_BYTES*8  message from the controller, sampled on the accept cycle only
- uart_out_req  input  1  send request; accepted when uart_out_req && uart_out_ready
- tx_data  output  8  byte to the UART transmitter
- tx_valid  output  1  tx_data is valid
- tx_ready  input  1  the transmitter takes the byte when tx_valid && tx_ready
- msg_done  output  1  one-cycle pulse after the final byte of a message is taken
- req_err  output  1  sticky; set by uart_out_req while uart_out_ready is low

## Operation
- Reset values: uart_out_ready=1, tx_valid=0, tx_data=0, msg_done=0, req_err=0. The state machine resets to IDLE, the byte counter to 0 and the checksum accumulator to 0.
- IDLE:
  - uart_out_ready=1 and tx_valid=0.
  - On an accept (uart_out_req=1), the block loads uart_out_msg into the shift register, clears the byte counter and the accumulator, and moves to SEND.
- SEND:
  - uart_out_ready=0, tx_valid=1, tx_data=shift[7:0].
  - On each handshake, the block shifts the register right by 8, increments the counter and adds tx_data to the accumulator (mod 256).
  - When the handshake takes the byte with counter==MSG_BYTES-1, the block goes to CSUM if checksum is enabled, otherwise to IDLE.
- CSUM (checksum build only):
  - tx_valid=1, tx_data=(~acc+1) mod 256, i.e. the two's complement of the byte sum.
  - On the handshake, the block goes to IDLE.
- msg_done is registered. It is 1 for exactly one cycle: the cycle after the last byte of a message is taken, which is also the first cycle that uart_out_ready=1 again.
- Once tx_valid is 1, tx_data holds stable until the handshake. tx_valid never drops mid-message except on reset.
- A uart_out_req while uart_out_ready=0 is ignored (the message is not captured) and sets req_err; only reset clears req_err.
- uart_out_msg is don't-care outside the accept cycle. The controller may change it freely while a message is in flight.
- Reset mid-message: the partial message is discarded with no further bytes and no msg_done. Outputs take their reset values on the next clock edge.
- The byte counter is $clog2(MSG_BYTES) bits wide. The accumulator is 8 bits and wraps.

## Timing
- Accept at cycle N puts byte 0 (the header) on tx_data with tx_valid=1 at cycle N+1.
- There are no bubbles: with tx_ready held at 1, byte k is taken at N+1+k. The last byte is taken at N+MSG_BYTES, or at N+MSG_BYTES+1 with checksum.
- msg_done and uart_out_ready rise in the cycle after the last byte is taken.
- The earliest next accept is that same cycle. The minimum message period is MSG_BYTES+1 cycles, or MSG_BYTES+2 with checksum.
- Backpressure with tx_ready=0 stalls the block indefinitely with no state change.
- uart_out_ready is a registered output; it does not depend combinationally on any input.

## Configuration
- UART_MSG_CHECKSUM_EN defined:
  - The CSUM state and accumulator are present.
  - Each message is sent as MSG_BYTES+1 bytes, and the sum of all transmitted bytes mod 256 is 0.
- UART_MSG_CHECKSUM_EN undefined:
  - There is no accumulator and no CSUM state.
  - Each message is sent as exactly MSG_BYTES bytes, and SEND returns directly to IDLE.

## Test plan
- Reset, then idle: uart_out_ready=1, tx_valid=0, msg_done=0 and req_err=0 for 10 cycles.
- MSG_BYTES=8, tx_ready=1, accept uart_out_msg=0x0807060504030201 at cycle N:
  - tx_data is 0x01..0x08 on cycles N+1..N+8.
  - With checksum, 0xDC follows at N+9.
  - msg_done pulses at N+9 (N+10 with checksum), and uart_out_ready is 1 in the same cycle.
- Backpressure: same message with tx_ready low for 5 cycles during byte 3 → tx_data holds 0x04 with tx_valid=1 throughout the stall; the byte order is unchanged; there are no duplicate or lost bytes.
- Back-to-back: issue the next req in the same cycle that msg_done is 1 with message 0x1111111111111111 → its byte 0 (0x11) appears the next cycle. With checksum, its checksum byte is 0x78.
- Illegal request: assert uart_out_req during SEND with a different message → req_err=1 and stays 1; the message in flight is unchanged; the ignored message is never transmitted.
- Reset mid-message: assert n_reset=0 after byte 2 is taken → tx_valid=0 on the next cycle, with no msg_done. After reset releases, uart_out_ready=1 and a new message transmits correctly.
